trs_video_pixel_gen: RTL and testbench

Character-row fetch and pixel serializer that sits downstream of the character-generator pROM (6-bit row data, 11-bit address) in the Model 1 video path.
- Accepts one character code plus scan row per character slot from the video timing / VRAM fetch stage.
- Generates the pROM address and enables, and captures the row after the pROM latency.
- Substitutes 2x3 block-graphics patterns for codes 0x80-0xFF.
- Shifts 6 pixels per character out to the video output, MSB first, with optional double-width (32-column) mode.

---
 rtl/trs_video_pixel_gen.sv | 197 +++++++++++++++++++
 tb/tb_trs_video_pixel_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trs_video_pixel_gen.sv
// Character-row fetch (pROM or 2x3 block graphics) feeding a 6-pixel MSB-first serializer, optional double width.
// Text rows land ROM_LAT+2 clk after handshake; char_ready stays low until the shifter takes the held row.
module trs_video_pixel_gen #(
  parameter int CHAR_W  = 6,
  parameter int ROM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_ce,
  input  logic              wide,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic [7:0]        char_code,
  input  logic [3:0]        row,
  input  logic              blank_in,
  output logic [10:0]       rom_ad,
  output logic              rom_ce,
  output logic              rom_oce,
  input  logic [CHAR_W-1:0] rom_dout,
  output logic              pixel,
  output logic              blank_out,
  output logic              underrun
);

  localparam int WW = $clog2(ROM_LAT + 1);
  localparam int CW = $clog2(CHAR_W);

  typedef enum logic [1:0] {IDLE, ROMWAIT, HOLD} state_t;

  state_t            state_q, state_d;
  logic              char_ready_q, char_ready_d;
  logic [10:0]       rom_ad_q, rom_ad_d;
  logic              rom_ce_q, rom_ce_d;
  logic              rom_oce_q, rom_oce_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              wide_lat_q, wide_lat_d;
  logic [CHAR_W-1:0] hold_dat_q, hold_dat_d;
  logic              hold_blank_q, hold_blank_d;
  logic              hold_wide_q, hold_wide_d;
  logic [CHAR_W-1:0] shift_q, shift_d;
  logic [CW-1:0]     pix_cnt_q, pix_cnt_d;
  logic              half_q, half_d;
  logic              cur_wide_q, cur_wide_d;
  logic              first_q, first_d;
  logic              pixel_q, pixel_d;
  logic              blank_out_q, blank_out_d;
  logic              underrun_q, underrun_d;

  logic hs, text_hs, advance, load, capture;

  assign hs      = char_valid & char_ready_q;
  assign text_hs = hs & ~char_code[7] & ~blank_in & (row < 4'd12);
  assign advance = pix_ce & (~cur_wide_q | half_q);
  assign load    = pix_ce & (first_q | (advance & (pix_cnt_q == CW'(CHAR_W - 1))));
  assign capture = (state_q == ROMWAIT) && (wait_q == WW'(ROM_LAT));

  // Each 2-bit row band: even bit lights the left half, odd bit the right half.
  function automatic logic [CHAR_W-1:0] gfx_pat(input logic [7:0] code, input logic [3:0] r);
    logic [1:0] pair;
    if (r < 4'd4)      pair = code[1:0];
    else if (r < 4'd8) pair = code[3:2];
    else               pair = code[5:4];
    return {{(CHAR_W / 2){pair[0]}}, {(CHAR_W - CHAR_W / 2){pair[1]}}};
  endfunction

  always_comb begin
    state_d      = state_q;
    rom_ad_d     = rom_ad_q;
    rom_ce_d     = 1'b0;
    rom_oce_d    = 1'b0;
    wait_d       = wait_q;
    wide_lat_d   = wide_lat_q;
    hold_dat_d   = hold_dat_q;
    hold_blank_d = hold_blank_q;
    hold_wide_d  = hold_wide_q;
    shift_d      = shift_q;
    pix_cnt_d    = pix_cnt_q;
    half_d       = half_q;
    cur_wide_d   = cur_wide_q;
    first_d      = first_q;
    blank_out_d  = blank_out_q;
    underrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          wide_lat_d = wide;
          if (text_hs) begin
            state_d  = ROMWAIT;
            rom_ad_d = {row[3], char_code[6:0], row[2:0]};
            rom_ce_d = 1'b1;
            wait_d   = '0;
          end else begin
            state_d      = HOLD;
            hold_dat_d   = (blank_in || row >= 4'd12) ? '0 : gfx_pat(char_code, row);
            hold_blank_d = blank_in;
            hold_wide_d  = wide;
          end
        end
      end
      ROMWAIT: begin
        wait_d    = wait_q + 1'b1;
        rom_oce_d = (wait_q == '0);
        if (capture) begin
          // A coincident load consumes the row directly, so the holding register stays empty.
          state_d      = load ? IDLE : HOLD;
          hold_dat_d   = rom_dout;
          hold_blank_d = 1'b0;
          hold_wide_d  = wide_lat_q;
        end
      end
      HOLD: begin
        if (load) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (pix_ce) half_d = ~half_q;

    if (load) begin
      first_d   = 1'b0;
      pix_cnt_d = '0;
      half_d    = 1'b0;
      if (state_q == HOLD) begin
        shift_d     = hold_dat_q;
        blank_out_d = hold_blank_q;
        cur_wide_d  = hold_wide_q;
      end else if (capture) begin
        shift_d     = rom_dout;
        blank_out_d = 1'b0;
        cur_wide_d  = wide_lat_q;
      end else begin
        shift_d     = '0;
        blank_out_d = 1'b1;
        cur_wide_d  = wide;
        underrun_d  = 1'b1;
      end
    end else if (advance) begin
      shift_d   = {shift_q[CHAR_W-2:0], 1'b0};
      pix_cnt_d = pix_cnt_q + 1'b1;
    end

    pixel_d      = shift_d[CHAR_W-1];
    char_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      char_ready_q <= 1'b0;
      rom_ad_q     <= '0;
      rom_ce_q     <= 1'b0;
      rom_oce_q    <= 1'b0;
      wait_q       <= '0;
      wide_lat_q   <= 1'b0;
      hold_dat_q   <= '0;
      hold_blank_q <= 1'b0;
      hold_wide_q  <= 1'b0;
      shift_q      <= '0;
      pix_cnt_q    <= '0;
      half_q       <= 1'b0;
      cur_wide_q   <= 1'b0;
      first_q      <= 1'b1;
      pixel_q      <= 1'b0;
      blank_out_q  <= 1'b1;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      char_ready_q <= char_ready_d;
      rom_ad_q     <= rom_ad_d;
      rom_ce_q     <= rom_ce_d;
      rom_oce_q    <= rom_oce_d;
      wait_q       <= wait_d;
      wide_lat_q   <= wide_lat_d;
      hold_dat_q   <= hold_dat_d;
      hold_blank_q <= hold_blank_d;
      hold_wide_q  <= hold_wide_d;
      shift_q      <= shift_d;
      pix_cnt_q    <= pix_cnt_d;
      half_q       <= half_d;
      cur_wide_q   <= cur_wide_d;
      first_q      <= first_d;
      pixel_q      <= pixel_d;
      blank_out_q  <= blank_out_d;
      underrun_q   <= underrun_d;
    end
  end

  assign char_ready = char_ready_q;
  assign rom_ad     = rom_ad_q;
  assign rom_ce     = rom_ce_q;
  assign rom_oce    = rom_oce_q;
  assign pixel      = pixel_q;
  assign blank_out  = blank_out_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_trs_video_pixel_gen.sv
// Directed bench for trs_video_pixel_gen with a two-stage pipelined pROM model.
module tb_trs_video_pixel_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pix_ce = 1'b0;
  logic        wide = 1'b0;
  logic        char_valid = 1'b0;
  logic [7:0]  char_code = 8'h00;
  logic [3:0]  row = 4'd0;
  logic        blank_in = 1'b0;
  logic        char_ready;
  logic [10:0] rom_ad;
  logic        rom_ce;
  logic        rom_oce;
  logic [5:0]  rom_dout;
  logic [5:0]  rom_stage;
  logic        pixel;
  logic        blank_out;
  logic        underrun;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trs_video_pixel_gen #(.CHAR_W(6), .ROM_LAT(2)) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .wide(wide),
    .char_valid(char_valid), .char_ready(char_ready), .char_code(char_code),
    .row(row), .blank_in(blank_in), .rom_ad(rom_ad), .rom_ce(rom_ce),
    .rom_oce(rom_oce), .rom_dout(rom_dout), .pixel(pixel),
    .blank_out(blank_out), .underrun(underrun)
  );

  function automatic logic [5:0] rom_fn(input logic [10:0] a);
    case (a)
      11'h208: rom_fn = 6'h04;
      11'h211: rom_fn = 6'h2D;
      default: rom_fn = 6'h15;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rom_ce)  rom_stage <= rom_fn(rom_ad);
    if (rom_oce) rom_dout  <= rom_stage;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c, input logic [3:0] r, input logic b, input logic w);
    int n = 0;
    while (char_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (char_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout: char_ready=%b, required 1", char_ready);
    end
    char_code  = c;
    row        = r;
    blank_in   = b;
    wide       = w;
    char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic show(input int n, output logic [11:0] p, output logic [11:0] bl, output int ur);
    p  = '0;
    bl = '0;
    ur = 0;
    for (int i = 0; i < n; i++) begin
      pix_ce = 1'b1;
      step();
      pix_ce = 1'b0;
      p  = {p[10:0], pixel};
      bl = {bl[10:0], blank_out};
      if (underrun === 1'b1) ur++;
    end
  endtask

  task automatic test_reset();
    step();
    tests++;
    if (char_ready !== 1'b0 || rom_ce !== 1'b0 || rom_oce !== 1'b0 || rom_ad !== 11'h000 ||
        pixel !== 1'b0 || blank_out !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b ce=%b oce=%b ad=%h pix=%b blk=%b ur=%b, required 0 0 0 000 0 1 0",
               char_ready, rom_ce, rom_oce, rom_ad, pixel, blank_out, underrun);
    end
    reset = 1'b1;
    step();
    tests++;
    if (char_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: char_ready=%b, required 1", char_ready);
    end
  endtask

  task automatic test_text();
    logic [11:0] p, bl;
    int ur;
    send_char(8'h41, 4'd0, 1'b0, 1'b0);
    tests++;
    if (rom_ce !== 1'b1 || rom_ad !== 11'h208 || char_ready !== 1'b0) begin
      fails++;
      $display("FAIL text_fetch: ce=%b ad=%h rdy=%b, required 1 208 0", rom_ce, rom_ad, char_ready);
    end
    step();
    tests++;
    if (rom_oce !== 1'b1 || rom_ce !== 1'b0) begin
      fails++;
      $display("FAIL text_oce: oce=%b ce=%b, required 1 0", rom_oce, rom_ce);
    end
    step(); step(); step();
    tests++;
    if (rom_oce !== 1'b0 || rom_ce !== 1'b0 || char_ready !== 1'b0) begin
      fails++;
      $display("FAIL text_hold: oce=%b ce=%b rdy=%b, required 0 0 0", rom_oce, rom_ce, char_ready);
    end
    show(6, p, bl, ur);
    tests++;
    if (p[5:0] !== 6'b000100) begin
      fails++;
      $display("FAIL text_pixels: got %b, required 000100", p[5:0]);
    end
    tests++;
    if (bl[5:0] !== 6'b000000 || ur != 0 || char_ready !== 1'b1) begin
      fails++;
      $display("FAIL text_flags: blank=%b underruns=%0d rdy=%b, required 000000 0 1", bl[5:0], ur, char_ready);
    end
  endtask

  task automatic test_graphics();
    logic [7:0] codes [6] = '{8'hBF, 8'hBF, 8'hBF, 8'h81, 8'h88, 8'h82};
    logic [3:0] rows  [6] = '{4'd0, 4'd5, 4'd10, 4'd2, 4'd5, 4'd5};
    logic [5:0] exps  [6] = '{6'h3F, 6'h3F, 6'h3F, 6'h38, 6'h07, 6'h00};
    logic [11:0] p, bl;
    int ur;
    logic ce_seen;
    for (int i = 0; i < 6; i++) begin
      send_char(codes[i], rows[i], 1'b0, 1'b0);
      ce_seen = rom_ce;
      step();
      ce_seen = ce_seen | rom_ce;
      show(6, p, bl, ur);
      tests++;
      if (p[5:0] !== exps[i] || ce_seen !== 1'b0) begin
        fails++;
        $display("FAIL gfx_%0d: code=%h row=%0d pixels=%b rom_ce_seen=%b, required %b 0",
                 i, codes[i], rows[i], p[5:0], ce_seen, exps[i]);
      end
      tests++;
      if (bl[5:0] !== 6'b000000 || ur != 0) begin
        fails++;
        $display("FAIL gfx_flags_%0d: blank=%b underruns=%0d, required 000000 0", i, bl[5:0], ur);
      end
    end
  endtask

  task automatic test_wide();
    logic [11:0] p, bl;
    int ur;
    send_char(8'h41, 4'd0, 1'b0, 1'b1);
    wide = 1'b0;
    step(); step(); step(); step();
    show(12, p, bl, ur);
    tests++;
    if (p !== 12'b000000110000 || bl !== 12'h000 || ur != 0) begin
      fails++;
      $display("FAIL wide_pixels: got %b blank=%b underruns=%0d, required 000000110000 000000000000 0", p, bl, ur);
    end
  endtask

  task automatic test_blank();
    logic [3:0] rows [3] = '{4'd12, 4'd12, 4'd0};
    logic       blks [3] = '{1'b0, 1'b1, 1'b1};
    logic [11:0] p, bl;
    int ur;
    logic ce_seen;
    for (int i = 0; i < 3; i++) begin
      send_char(8'h41, rows[i], blks[i], 1'b0);
      ce_seen = rom_ce;
      step();
      ce_seen = ce_seen | rom_ce;
      show(6, p, bl, ur);
      tests++;
      if (p[5:0] !== 6'b000000 || ce_seen !== 1'b0 || ur != 0) begin
        fails++;
        $display("FAIL blank_pix_%0d: pixels=%b rom_ce_seen=%b underruns=%0d, required 000000 0 0",
                 i, p[5:0], ce_seen, ur);
      end
      if (blks[i]) begin
        tests++;
        if (bl[5:0] !== 6'b111111) begin
          fails++;
          $display("FAIL blank_flag_%0d: blank_out=%b, required 111111", i, bl[5:0]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    logic [11:0] p, bl;
    int ur;
    show(6, p, bl, ur);
    tests++;
    if (ur != 1 || p[5:0] !== 6'b000000 || bl[5:0] !== 6'b111111) begin
      fails++;
      $display("FAIL underrun_idle: underruns=%0d pixels=%b blank=%b, required 1 000000 111111", ur, p[5:0], bl[5:0]);
    end
    send_char(8'hBF, 4'd0, 1'b0, 1'b0);
    show(6, p, bl, ur);
    tests++;
    if (ur != 0 || p[5:0] !== 6'b111111 || bl[5:0] !== 6'b000000) begin
      fails++;
      $display("FAIL underrun_recover: underruns=%0d pixels=%b blank=%b, required 0 111111 000000", ur, p[5:0], bl[5:0]);
    end
  endtask

  task automatic test_romwait_underrun();
    logic [11:0] p, bl;
    int ur;
    send_char(8'h42, 4'd1, 1'b0, 1'b0);
    step();
    show(6, p, bl, ur);
    tests++;
    if (ur != 1 || p[5:0] !== 6'b000000 || bl[5:0] !== 6'b111111) begin
      fails++;
      $display("FAIL romwait_underrun: underruns=%0d pixels=%b blank=%b, required 1 000000 111111", ur, p[5:0], bl[5:0]);
    end
    show(6, p, bl, ur);
    tests++;
    if (ur != 0 || p[5:0] !== 6'b101101 || bl[5:0] !== 6'b000000) begin
      fails++;
      $display("FAIL romwait_late: underruns=%0d pixels=%b blank=%b, required 0 101101 000000", ur, p[5:0], bl[5:0]);
    end
  endtask

  task automatic test_bypass();
    logic [11:0] p, bl;
    int ur;
    send_char(8'h42, 4'd1, 1'b0, 1'b0);
    step(); step();
    show(6, p, bl, ur);
    tests++;
    if (ur != 0 || p[5:0] !== 6'b101101 || bl[5:0] !== 6'b000000 || char_ready !== 1'b1) begin
      fails++;
      $display("FAIL bypass: underruns=%0d pixels=%b blank=%b rdy=%b, required 0 101101 000000 1",
               ur, p[5:0], bl[5:0], char_ready);
    end
  endtask

  task automatic test_reset_midfetch();
    logic [11:0] p, bl;
    int ur;
    send_char(8'h41, 4'd0, 1'b0, 1'b0);
    step();
    tests++;
    if (rom_oce !== 1'b1 || pixel !== 1'b1 || blank_out !== 1'b0) begin
      fails++;
      $display("FAIL midfetch_pre: oce=%b pix=%b blk=%b, required 1 1 0", rom_oce, pixel, blank_out);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (char_ready !== 1'b0 || rom_ce !== 1'b0 || rom_oce !== 1'b0 || rom_ad !== 11'h000 ||
        pixel !== 1'b0 || blank_out !== 1'b1 || underrun !== 1'b0) begin
      fails++;
      $display("FAIL midfetch_reset: rdy=%b ce=%b oce=%b ad=%h pix=%b blk=%b ur=%b, required 0 0 0 000 0 1 0",
               char_ready, rom_ce, rom_oce, rom_ad, pixel, blank_out, underrun);
    end
    step(); step();
    reset = 1'b1;
    step();
    tests++;
    if (char_ready !== 1'b1) begin
      fails++;
      $display("FAIL midfetch_ready: char_ready=%b, required 1", char_ready);
    end
    send_char(8'h42, 4'd1, 1'b0, 1'b0);
    tests++;
    if (rom_ad !== 11'h211 || rom_ce !== 1'b1) begin
      fails++;
      $display("FAIL midfetch_refetch: ad=%h ce=%b, required 211 1", rom_ad, rom_ce);
    end
    step(); step(); step(); step();
    show(6, p, bl, ur);
    tests++;
    if (ur != 0 || p[5:0] !== 6'b101101 || bl[5:0] !== 6'b000000) begin
      fails++;
      $display("FAIL midfetch_clean: underruns=%0d pixels=%b blank=%b, required 0 101101 000000", ur, p[5:0], bl[5:0]);
    end
  endtask

  initial begin
    test_reset();
    test_text();
    test_graphics();
    test_wide();
    test_blank();
    test_underrun();
    test_romwait_underrun();
    test_bypass();
    test_reset_midfetch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
